mux_sel_sequencer: RTL

//  Control stage directly upstream of the 4-to-1 case multiplexer: arbitrates four request lines and

---
 rtl/mux_sel_sequencer_pkg.sv | 20 ++
 rtl/mux_sel_pick4.sv | 44 ++++
 rtl/mux_sel_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the mux select sequencer.
// Holds the input count, select width and FSM state encodings.
package mux_sel_sequencer_pkg;

  localparam int N_IN  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  function automatic logic [N_IN-1:0] onehot(
    input logic [SEL_W-1:0] s
  );
    onehot = N_IN'(1) << s;
  endfunction

endpackage

// File: rtl/mux_sel_pick4.sv
// Combinational 4-way winner pick for the select sequencer.
// Round-robin after ptr by default; FIXED_PRIO_EN gives req[0] priority.
module mux_sel_pick4
  import mux_sel_sequencer_pkg::*;
(
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

`ifdef FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // lowest asserted index wins
  always_comb begin
    any = |req;
    win = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (req[i]) win = SEL_W'(i);
    end
  end
`else
  logic             found;
  logic [SEL_W-1:0] idx;

  // scan ptr+1 .. ptr+4 (wraps), first hit wins
  always_comb begin
    any   = |req;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_IN; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mux_sel_sequencer.sv
// Select/grant sequencer feeding a 4:1 mux, DWELL beats per slot.
// Define FIXED_PRIO_EN for fixed priority pick instead of round-robin.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_IN-1:0]  req,
  input  logic             ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_IN-1:0]  grant,
  output logic             valid,
  output logic             busy
);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win;
  logic             any;
  logic             accept;
  logic             withdraw;
  logic             slot_end;
  logic             launch;

  mux_sel_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  assign accept   = valid & ready;
  assign withdraw = ~req[sel];

  // a slot closes on its last accepted beat or when its requester leaves
  assign slot_end =
    ((state == ST_HOLD) & accept & (cnt == '0)) |
    ((state != ST_IDLE) & withdraw);

  // open a new slot from idle, or chain one with no bubble
  assign launch =
    en & any & ((state == ST_IDLE) | slot_end);

  // FSM, beat counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= '0;
      grant <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
      ptr   <= SEL_W'(N_IN - 1);
    end else if (launch) begin
      state <= ST_HOLD;
      sel   <= win;
      grant <= onehot(win);
      valid <= 1'b1;
      busy  <= 1'b1;
      cnt   <= CW'(DWELL - 1);
      ptr   <= win;
    end else if (slot_end) begin
      state <= ST_IDLE;
      grant <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        ST_HOLD: begin
          if (accept) cnt <= cnt - 1'b1;
          if (!en) begin
            state <= ST_PAUSE;
            valid <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (en) begin
            state <= ST_HOLD;
            valid <= 1'b1;
          end
        end
        ST_IDLE: begin
          valid <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
